// File: rtl/config_loader.sv
// config_loader: drives the LE configuration chain. Bitstream words arrive on a
// valid/ready port and are shifted MSB-first into the chain head. Readback
// recirculates the chain tail into the head, so the chain contents survive a
// full readback pass. Readback words leave on a second valid/ready port.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | no pass in progress, waiting for load_start / rb_start
// LD_WAIT  | load pass, wr_ready high, waiting for the next word
// LD_SHIFT | load pass, shifting the latched word into the chain
// RB_SHIFT | readback pass, recirculating tail->head, collecting bits
// RB_HOLD  | readback pass, word presented on rd_data until rd_ready
module config_loader #(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 68
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              en,
  input  logic              load_start,
  input  logic              rb_start,
  input  logic              abort,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              config_data_in,
  output logic              config_en,
  input  logic              config_data_out,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LD_WAIT,
    LD_SHIFT,
    RB_SHIFT,
    RB_HOLD
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [IDX_W-1:0]  bit_idx;
  logic [WORD_W-1:0] shreg;
  logic              shift_q;
  logic              ld_bit;

  logic              last_chain_bit;
  logic              last_word_bit;
  logic [WORD_W-1:0] rb_next;
  logic [IDX_W-1:0]  pad;

  // Position decode and the next readback word (tail bit enters the LSB).
  // pad left-aligns a partial final word, zero-filling its LSBs.
  always_comb begin
    last_chain_bit = (bit_cnt == CNT_W'(CHAIN_LEN - 1));
    last_word_bit  = (bit_idx == IDX_W'(WORD_W - 1));
    rb_next        = {shreg[WORD_W-2:0], config_data_out};
    pad            = IDX_W'(WORD_W - 1) - bit_idx;
  end

  // Chain-facing outputs; readback feeds the tail straight back to the head so
  // the bit re-enters on the same shift edge it leaves.
  always_comb begin
    config_en      = shift_q & en;
    config_data_in = 1'b0;
    if (config_en)
      config_data_in = (state == RB_SHIFT) ? config_data_out : ld_bit;
    busy = (state != IDLE);
  end

  // Sequencer: state, counters, shift register and registered handshake outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      shift_q  <= 1'b0;
      ld_bit   <= 1'b0;
      wr_ready <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      done     <= 1'b0;
    end else if (en) begin
      done <= 1'b0;
      if (abort) begin
        state    <= IDLE;
        shift_q  <= 1'b0;
        ld_bit   <= 1'b0;
        wr_ready <= 1'b0;
        rd_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (load_start) begin
              state    <= LD_WAIT;
              wr_ready <= 1'b1;
              bit_cnt  <= '0;
            end else if (rb_start) begin
              state   <= RB_SHIFT;
              shift_q <= 1'b1;
              bit_cnt <= '0;
              bit_idx <= '0;
            end
          end
          LD_WAIT: begin
            if (wr_valid && wr_ready) begin
              state    <= LD_SHIFT;
              wr_ready <= 1'b0;
              shift_q  <= 1'b1;
              ld_bit   <= wr_data[WORD_W-1];
              shreg    <= wr_data << 1;
              bit_idx  <= '0;
            end
          end
          LD_SHIFT: begin
            bit_cnt <= bit_cnt + 1'b1;
            bit_idx <= bit_idx + 1'b1;
            ld_bit  <= shreg[WORD_W-1];
            shreg   <= shreg << 1;
            if (last_chain_bit) begin
              // Chain full: leftover LSBs of a partial final word are dropped.
              state   <= IDLE;
              shift_q <= 1'b0;
              ld_bit  <= 1'b0;
              done    <= 1'b1;
            end else if (last_word_bit) begin
              state    <= LD_WAIT;
              shift_q  <= 1'b0;
              ld_bit   <= 1'b0;
              wr_ready <= 1'b1;
            end
          end
          RB_SHIFT: begin
            bit_cnt <= bit_cnt + 1'b1;
            bit_idx <= bit_idx + 1'b1;
            shreg   <= rb_next;
            if (last_chain_bit || last_word_bit) begin
              state    <= RB_HOLD;
              shift_q  <= 1'b0;
              rd_valid <= 1'b1;
              rd_data  <= rb_next << pad;
            end
          end
          RB_HOLD: begin
            if (rd_ready) begin
              rd_valid <= 1'b0;
              if (bit_cnt == CNT_W'(CHAIN_LEN)) begin
                state <= IDLE;
                done  <= 1'b1;
              end else begin
                state   <= RB_SHIFT;
                shift_q <= 1'b1;
                bit_idx <= '0;
              end
            end
          end
          default: begin
            state   <= IDLE;
            shift_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader with a behavioural 17-bit chain
// (4 LEs' worth shortened to 17 bits). chain[16] is the tail.
module tb_config_loader;

  localparam int WORD_W    = 8;
  localparam int CHAIN_LEN = 17;
  localparam logic [16:0] EXP_CHAIN = 17'b1_0100_1010_0111_1001;

  logic              clk = 1'b0;
  logic              nrst;
  logic              en;
  logic              load_start;
  logic              rb_start;
  logic              abort;
  logic [WORD_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [WORD_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready;
  logic              config_data_in;
  logic              config_en;
  logic              config_data_out;
  logic              busy;
  logic              done;

  logic              clr_chain = 1'b0;
  logic [16:0]       chain = '0;
  int                cfg_cycles = 0;
  int                done_cnt = 0;
  int                n_tests = 0;
  int                n_fail = 0;

  always #5 clk = ~clk;

  config_loader #(.WORD_W(WORD_W), .CHAIN_LEN(CHAIN_LEN)) dut (
    .clk             (clk),
    .nrst            (nrst),
    .en              (en),
    .load_start      (load_start),
    .rb_start        (rb_start),
    .abort           (abort),
    .wr_data         (wr_data),
    .wr_valid        (wr_valid),
    .wr_ready        (wr_ready),
    .rd_data         (rd_data),
    .rd_valid        (rd_valid),
    .rd_ready        (rd_ready),
    .config_data_in  (config_data_in),
    .config_en       (config_en),
    .config_data_out (config_data_out),
    .busy            (busy),
    .done            (done)
  );

  assign config_data_out = chain[16];

  // Chain model plus shift-cycle and done-pulse counters.
  always @(posedge clk) begin
    if (clr_chain) chain <= '0;
    else if (en && config_en) chain <= {chain[15:0], config_data_in};
    if (en && config_en) cfg_cycles <= cfg_cycles + 1;
    if (en && done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int k = 0;
    while (wr_ready !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("wr_ready_wait", {31'd0, wr_ready}, 32'd1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy !== 1'b0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("idle_wait", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic send_word(input logic [7:0] w, input int gap);
    logic [16:0] snap;
    wait_ready();
    snap = chain;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      chk("gap_config_en", {31'd0, config_en}, 32'd0);
      chk("gap_chain", {15'd0, chain}, {15'd0, snap});
    end
    wr_data  = w;
    wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic recv_word(input logic [7:0] exp, input int hold);
    int k = 0;
    rd_ready = (hold == 0);
    while (rd_valid !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("rd_valid_wait", {31'd0, rd_valid}, 32'd1);
    chk("rd_data", {24'd0, rd_data}, {24'd0, exp});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_rd_valid", {31'd0, rd_valid}, 32'd1);
      chk("hold_rd_data", {24'd0, rd_data}, {24'd0, exp});
      chk("hold_config_en", {31'd0, config_en}, 32'd0);
    end
    rd_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_load(input int gap);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    send_word(8'hA5, gap);
    send_word(8'h3C, gap);
    send_word(8'h80, gap);
    wait_idle();
  endtask

  task automatic do_rb(input int hold2);
    rb_start = 1'b1;
    @(negedge clk);
    rb_start = 1'b0;
    recv_word(8'hA5, 0);
    recv_word(8'h3C, hold2);
    recv_word(8'h80, 0);
    wait_idle();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wr_ready"}, {31'd0, wr_ready}, 32'd0);
    chk({tag, "_rd_valid"}, {31'd0, rd_valid}, 32'd0);
    chk({tag, "_config_en"}, {31'd0, config_en}, 32'd0);
    chk({tag, "_config_data_in"}, {31'd0, config_data_in}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_rd_data"}, {24'd0, rd_data}, 32'd0);
  endtask

  initial begin
    int c0;
    int d0;
    logic [16:0] exp_ab;
    logic [16:0] snap;

    nrst = 1'b0; en = 1'b1; load_start = 1'b0; rb_start = 1'b0; abort = 1'b0;
    wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    nrst = 1'b1;
    @(negedge clk);

    // 1: plain load of three words into the 17-bit chain
    c0 = cfg_cycles; d0 = done_cnt;
    do_load(0);
    chk("t1_cfg_cycles", cfg_cycles - c0, 32'd17);
    chk("t1_chain", {15'd0, chain}, {15'd0, EXP_CHAIN});
    chk("t1_done", done_cnt - d0, 32'd1);
    chk("t1_wr_ready", {31'd0, wr_ready}, 32'd0);

    // 2: readback returns the same words and leaves the chain intact
    c0 = cfg_cycles; d0 = done_cnt;
    do_rb(0);
    chk("t2_chain", {15'd0, chain}, {15'd0, EXP_CHAIN});
    chk("t2_cfg_cycles", cfg_cycles - c0, 32'd17);
    chk("t2_done", done_cnt - d0, 32'd1);

    // 3: load from a cleared chain with 5-cycle gaps before each word
    clr_chain = 1'b1;
    @(negedge clk);
    clr_chain = 1'b0;
    c0 = cfg_cycles; d0 = done_cnt;
    do_load(5);
    chk("t3_chain", {15'd0, chain}, {15'd0, EXP_CHAIN});
    chk("t3_cfg_cycles", cfg_cycles - c0, 32'd17);
    chk("t3_done", done_cnt - d0, 32'd1);

    // 4: readback with consumer stalling 10 cycles on word 2
    c0 = cfg_cycles; d0 = done_cnt;
    do_rb(10);
    chk("t4_chain", {15'd0, chain}, {15'd0, EXP_CHAIN});
    chk("t4_cfg_cycles", cfg_cycles - c0, 32'd17);
    chk("t4_done", done_cnt - d0, 32'd1);

    // 5a: abort after 5 bits of a load of 0xFF
    d0 = done_cnt;
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    wait_ready();
    wr_data = 8'hFF; wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    c0 = cfg_cycles;
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t5_config_en", {31'd0, config_en}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_wr_ready", {31'd0, wr_ready}, 32'd0);
    chk("t5_bits_shifted", cfg_cycles - c0, 32'd5);
    exp_ab = EXP_CHAIN;
    exp_ab = {exp_ab[11:0], 5'b11111};
    chk("t5_chain", {15'd0, chain}, {15'd0, exp_ab});
    repeat (3) @(negedge clk);
    chk("t5_no_done", done_cnt - d0, 32'd0);

    // 5b: reset in the middle of a readback
    d0 = done_cnt;
    rb_start = 1'b1;
    @(negedge clk);
    rb_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_rb_shifting", {31'd0, config_en}, 32'd1);
    nrst = 1'b0;
    #1;
    chk_all_zero("t5_rst");
    @(negedge clk);
    nrst = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5_rst_no_done", done_cnt - d0, 32'd0);

    // 6a: en low for 3 cycles in the middle of shifting word 1
    c0 = cfg_cycles; d0 = done_cnt;
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    send_word(8'hA5, 0);
    repeat (3) @(negedge clk);
    en = 1'b0;
    snap = chain;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_en_config_en", {31'd0, config_en}, 32'd0);
      chk("t6_en_busy", {31'd0, busy}, 32'd1);
      chk("t6_en_chain", {15'd0, chain}, {15'd0, snap});
    end
    en = 1'b1;
    send_word(8'h3C, 0);
    send_word(8'h80, 0);
    wait_idle();
    chk("t6_chain", {15'd0, chain}, {15'd0, EXP_CHAIN});
    chk("t6_cfg_cycles", cfg_cycles - c0, 32'd17);
    chk("t6_done", done_cnt - d0, 32'd1);

    // 6b: simultaneous starts -> load pass wins
    load_start = 1'b1; rb_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0; rb_start = 1'b0;
    chk("t6_both_wr_ready", {31'd0, wr_ready}, 32'd1);
    chk("t6_both_busy", {31'd0, busy}, 32'd1);
    chk("t6_both_config_en", {31'd0, config_en}, 32'd0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t6_abort_busy", {31'd0, busy}, 32'd0);
    chk("t6_abort_wr_ready", {31'd0, wr_ready}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
